// File: rtl/strait_selftest_sequencer.sv
// Power-on self-test sequencer for the STRAIT accelerator.
// One host request runs MBIST, then LBIST (stuck-at, then transition-delay),
// then waits for BISR weight reallocation. A sticky status word is kept for the host.
// Every output is registered and decoded from the next state, so the outputs
// line up with the state the FSM enters on that clock edge.
module strait_selftest_sequencer #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run_req,
    input  logic       skip_mbist,
    output logic       START,
    output logic       test_mode,
    output logic       BIST_mode,
    input  logic       test_done,
    input  logic       MBIST_FAIL,
    input  logic       TD_error_flag,
    input  logic       recovery_done,
    input  logic       recovery_success,
    output logic       busy,
    output logic       seq_done,
    output logic [2:0] phase,
    output logic       mbist_fail_o,
    output logic       td_error_o,
    output logic       repair_ok_o,
    output logic       timeout_o
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_MB_SETUP,
        S_MB_START,
        S_MB_WAIT,
        S_LB_SETUP,
        S_LB_START,
        S_LB_WAIT,      // SA_WAIT when td_sel=0, TD_WAIT when td_sel=1
        S_REPAIR_WAIT,
        S_DONE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t               state, state_nx;
    logic                 td_sel, td_sel_nx;
    logic                 rec_seen, rec_seen_nx;
    logic                 rec_ok, rec_ok_nx;
    logic [CNT_WIDTH-1:0] cnt, cnt_nx;
    logic                 mbist_fail_nx, td_error_nx, repair_ok_nx, timeout_nx;
    logic                 in_wait, expired;

    // Host-visible phase code; DONE reports as idle.
    function automatic logic [2:0] phase_of(input state_t s);
        case (s)
            S_MB_SETUP:    phase_of = 3'd1;
            S_MB_START:    phase_of = 3'd2;
            S_MB_WAIT:     phase_of = 3'd3;
            S_LB_SETUP:    phase_of = 3'd4;
            S_LB_START:    phase_of = 3'd5;
            S_LB_WAIT:     phase_of = 3'd6;
            S_REPAIR_WAIT: phase_of = 3'd7;
            default:       phase_of = 3'd0;
        endcase
    endfunction

    // Next-state, sticky status and timeout counter logic.
    always_comb begin
        state_nx      = state;
        td_sel_nx     = td_sel;
        rec_seen_nx   = rec_seen;
        rec_ok_nx     = rec_ok;
        mbist_fail_nx = mbist_fail_o;
        td_error_nx   = td_error_o;
        repair_ok_nx  = repair_ok_o;
        timeout_nx    = timeout_o;
        cnt_nx        = '0;

        in_wait = (state == S_MB_WAIT) || (state == S_LB_WAIT) || (state == S_REPAIR_WAIT);
        expired = in_wait && (cnt == CNT_LAST);

        // A recovery_done that arrives before REPAIR_WAIT is remembered so it is not lost.
        if ((state == S_LB_START || state == S_LB_WAIT || state == S_REPAIR_WAIT) && recovery_done) begin
            rec_seen_nx = 1'b1;
            rec_ok_nx   = recovery_success;
        end

        case (state)
            S_IDLE: begin
                if (run_req) begin
                    mbist_fail_nx = 1'b0;
                    td_error_nx   = 1'b0;
                    repair_ok_nx  = 1'b0;
                    timeout_nx    = 1'b0;
                    rec_seen_nx   = 1'b0;
                    rec_ok_nx     = 1'b0;
                    td_sel_nx     = 1'b0;
                    state_nx      = skip_mbist ? S_LB_SETUP : S_MB_SETUP;
                end
            end
            S_MB_SETUP: state_nx = S_MB_START;
            S_MB_START: state_nx = S_MB_WAIT;
            S_MB_WAIT: begin
                if (test_done) begin
                    mbist_fail_nx = MBIST_FAIL;
                    state_nx      = MBIST_FAIL ? S_DONE : S_LB_SETUP;
                end else if (expired) begin
                    timeout_nx = 1'b1;
                    state_nx   = S_DONE;
                end
            end
            S_LB_SETUP: state_nx = S_LB_START;
            S_LB_START: begin
                td_sel_nx = 1'b0;
                state_nx  = S_LB_WAIT;
            end
            S_LB_WAIT: begin
                if (test_done && !td_sel) begin
                    td_sel_nx = 1'b1;
                end else if (test_done) begin
                    td_error_nx = TD_error_flag;
                    // With repair already reported, the TD end is the final event.
                    if (recovery_done) begin
                        repair_ok_nx = recovery_success;
                        state_nx     = S_DONE;
                    end else if (rec_seen) begin
                        repair_ok_nx = rec_ok;
                        state_nx     = S_DONE;
                    end else begin
                        state_nx = S_REPAIR_WAIT;
                    end
                end else if (expired) begin
                    timeout_nx = 1'b1;
                    state_nx   = S_DONE;
                end
            end
            S_REPAIR_WAIT: begin
                if (recovery_done) begin
                    repair_ok_nx = recovery_success;
                    state_nx     = S_DONE;
                end else if (rec_seen) begin
                    repair_ok_nx = rec_ok;
                    state_nx     = S_DONE;
                end else if (expired) begin
                    timeout_nx = 1'b1;
                    state_nx   = S_DONE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase

        // Counter restarts on entry to each wait (including SA -> TD) and runs inside it.
        if (state_nx != state || td_sel_nx != td_sel) begin
            cnt_nx = '0;
        end else if (in_wait) begin
            cnt_nx = cnt + CNT_WIDTH'(1);
        end
    end

    // FSM state, sub-phase flag, early-recovery memory and timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            td_sel   <= 1'b0;
            rec_seen <= 1'b0;
            rec_ok   <= 1'b0;
            cnt      <= '0;
        end else begin
            state    <= state_nx;
            td_sel   <= td_sel_nx;
            rec_seen <= rec_seen_nx;
            rec_ok   <= rec_ok_nx;
            cnt      <= cnt_nx;
        end
    end

    // Registered STRAIT controls, host handshake and sticky status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            START        <= 1'b0;
            test_mode    <= 1'b0;
            BIST_mode    <= 1'b0;
            busy         <= 1'b0;
            seq_done     <= 1'b0;
            phase        <= 3'd0;
            mbist_fail_o <= 1'b0;
            td_error_o   <= 1'b0;
            repair_ok_o  <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            START        <= (state_nx == S_MB_START) || (state_nx == S_LB_START);
            test_mode    <= (state_nx != S_IDLE) && (state_nx != S_DONE);
            BIST_mode    <= (state_nx == S_LB_SETUP) || (state_nx == S_LB_START) ||
                            (state_nx == S_LB_WAIT)  || (state_nx == S_REPAIR_WAIT);
            busy         <= (state_nx != S_IDLE) && (state_nx != S_DONE);
            seq_done     <= (state_nx == S_DONE);
            phase        <= phase_of(state_nx);
            mbist_fail_o <= mbist_fail_nx;
            td_error_o   <= td_error_nx;
            repair_ok_o  <= repair_ok_nx;
            timeout_o    <= timeout_nx;
        end
    end

endmodule

// File: tb/tb_strait_selftest_sequencer.sv
// Scoreboard bench for strait_selftest_sequencer: the stimulus process queues
// expected output snapshots and expected sequence results; the monitor process
// pops and compares them as the DUT presents outputs.
module tb_strait_selftest_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run_req, skip_mbist, test_done, MBIST_FAIL, TD_error_flag;
    logic       recovery_done, recovery_success;
    logic       START, test_mode, BIST_mode, busy, seq_done;
    logic [2:0] phase;
    logic       mbist_fail_o, td_error_o, repair_ok_o, timeout_o;
    logic [11:0] ov;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic end_req = 1'b0;
    logic end_ack = 1'b0;

    typedef struct packed {
        int          tag;
        logic [11:0] vec;
    } snap_t;

    typedef struct packed {
        logic [3:0] stat;   // {mbist_fail, td_error, repair_ok, timeout}
        logic [1:0] nst;    // START pulses in the sequence
        logic [1:0] bmask;  // BIST_mode at each START, bit0 = first
        logic       bever;  // BIST_mode ever high while busy
        int         cyc_exp;
    } done_t;

    snap_t snap_q[$];
    done_t done_q[$];

    strait_selftest_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .run_req(run_req), .skip_mbist(skip_mbist),
        .START(START), .test_mode(test_mode), .BIST_mode(BIST_mode),
        .test_done(test_done), .MBIST_FAIL(MBIST_FAIL), .TD_error_flag(TD_error_flag),
        .recovery_done(recovery_done), .recovery_success(recovery_success),
        .busy(busy), .seq_done(seq_done), .phase(phase),
        .mbist_fail_o(mbist_fail_o), .td_error_o(td_error_o),
        .repair_ok_o(repair_ok_o), .timeout_o(timeout_o)
    );

    assign ov = {START, test_mode, BIST_mode, busy, seq_done, phase,
                 mbist_fail_o, td_error_o, repair_ok_o, timeout_o};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0h want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    initial begin : monitor
        snap_t s;
        done_t d;
        int    nstart;
        logic [1:0] bmask;
        logic  bever, prev_bist, post_chk, post_bist;
        nstart = 0; bmask = 2'b00; bever = 1'b0;
        prev_bist = 1'b0; post_chk = 1'b0; post_bist = 1'b0;
        forever begin
            @(negedge clk);
            if (snap_q.size() > 0) begin
                s = snap_q.pop_front();
                chk($sformatf("snap%0d_outputs", s.tag), int'(ov), int'(s.vec));
            end
            if (!rst_n) begin
                nstart = 0; bmask = 2'b00; bever = 1'b0;
                prev_bist = 1'b0; post_chk = 1'b0;
            end else begin
                if (post_chk) begin
                    chk("bist_after_start", int'(BIST_mode), int'(post_bist));
                    post_chk = 1'b0;
                end
                if (START === 1'b1) begin
                    chk("bist_before_start", int'(BIST_mode), int'(prev_bist));
                    if (nstart == 0) bmask[0] = BIST_mode;
                    else bmask[1] = BIST_mode;
                    nstart++;
                    post_chk  = 1'b1;
                    post_bist = BIST_mode;
                end
                if (busy === 1'b1 && BIST_mode === 1'b1) bever = 1'b1;
                prev_bist = BIST_mode;
                if (seq_done === 1'b1) begin
                    if (done_q.size() == 0) begin
                        chk("unexpected_seq_done", 1, 0);
                    end else begin
                        d = done_q.pop_front();
                        chk("done_cycle",   cyc, d.cyc_exp);
                        chk("mbist_fail_o", int'(mbist_fail_o), int'(d.stat[3]));
                        chk("td_error_o",   int'(td_error_o),   int'(d.stat[2]));
                        chk("repair_ok_o",  int'(repair_ok_o),  int'(d.stat[1]));
                        chk("timeout_o",    int'(timeout_o),    int'(d.stat[0]));
                        chk("start_count",  nstart,             int'(d.nst));
                        chk("bist_at_start", int'(bmask),       int'(d.bmask));
                        chk("bist_ever",    int'(bever),        int'(d.bever));
                        chk("busy_at_done", int'(busy),         0);
                        chk("phase_at_done", int'(phase),       0);
                    end
                    nstart = 0; bmask = 2'b00; bever = 1'b0;
                end
            end
            if (end_req && !end_ack) begin
                chk("pending_sequences", done_q.size(), 0);
                end_ack = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at(input int c);
        while (cyc < c) tick();
    endtask

    task automatic snap(input int tag, input logic st, input logic tm, input logic bm,
                        input logic bz, input logic sd, input logic [2:0] ph,
                        input logic [3:0] stat);
        snap_t s;
        s.tag = tag;
        s.vec = {st, tm, bm, bz, sd, ph, stat};
        snap_q.push_back(s);
    endtask

    task automatic expect_done(input int c, input logic [3:0] stat, input logic [1:0] nst,
                               input logic [1:0] bmask, input logic bever);
        done_t d;
        d.stat = stat; d.nst = nst; d.bmask = bmask; d.bever = bever; d.cyc_exp = c;
        done_q.push_back(d);
    endtask

    task automatic run(input logic skip);
        run_req = 1'b1; skip_mbist = skip;
        tick();
        run_req = 1'b0; skip_mbist = 1'b0;
    endtask

    task automatic pulse_td(input logic mf, input logic tde);
        test_done = 1'b1; MBIST_FAIL = mf; TD_error_flag = tde;
        tick();
        test_done = 1'b0; MBIST_FAIL = 1'b0; TD_error_flag = 1'b0;
    endtask

    task automatic pulse_rec(input logic ok);
        recovery_done = 1'b1; recovery_success = ok;
        tick();
        recovery_done = 1'b0; recovery_success = 1'b0;
    endtask

    initial begin : stimulus
        int b;
        rst_n = 1'b0; run_req = 1'b0; skip_mbist = 1'b0; test_done = 1'b0;
        MBIST_FAIL = 1'b0; TD_error_flag = 1'b0; recovery_done = 1'b0; recovery_success = 1'b0;
        repeat (2) tick();
        snap(0, 0, 0, 0, 0, 0, 3'd0, 4'b0000);
        rst_n = 1'b1;
        tick();
        snap(1, 0, 0, 0, 0, 0, 3'd0, 4'b0000);
        tick();

        // Clean run: MBIST pass, SA, TD clean, repair succeeds 5 cycles after TD.
        b = cyc;
        run(1'b0);
        snap(10, 0, 1, 0, 1, 0, 3'd1, 4'b0000);
        tick();
        snap(11, 1, 1, 0, 1, 0, 3'd2, 4'b0000);
        at(b + 12); pulse_td(1'b0, 1'b0);
        snap(12, 0, 1, 1, 1, 0, 3'd4, 4'b0000);
        at(b + 24); pulse_td(1'b0, 1'b0);
        at(b + 34); pulse_td(1'b0, 1'b0);
        snap(13, 0, 1, 1, 1, 0, 3'd7, 4'b0000);
        at(b + 39); expect_done(b + 40, 4'b0010, 2'd2, 2'b10, 1'b1); pulse_rec(1'b1);
        repeat (3) tick();

        // MBIST fail: LBIST skipped.
        b = cyc;
        run(1'b0);
        at(b + 12); expect_done(b + 13, 4'b1000, 2'd1, 2'b00, 1'b0); pulse_td(1'b1, 1'b0);
        snap(20, 0, 0, 0, 0, 1, 3'd0, 4'b1000);
        tick();
        snap(21, 0, 0, 0, 0, 0, 3'd0, 4'b1000);
        repeat (3) tick();

        // Skip MBIST, TD error, repair fails.
        b = cyc;
        run(1'b1);
        snap(30, 0, 1, 1, 1, 0, 3'd4, 4'b0000);
        tick();
        snap(31, 1, 1, 1, 1, 0, 3'd5, 4'b0000);
        at(b + 12); pulse_td(1'b0, 1'b0);
        at(b + 22); pulse_td(1'b0, 1'b1);
        snap(32, 0, 1, 1, 1, 0, 3'd7, 4'b0100);
        at(b + 27); expect_done(b + 28, 4'b0100, 2'd1, 2'b01, 1'b1); pulse_rec(1'b0);
        repeat (3) tick();

        // Early recovery during SA_WAIT: sequence ends 1 cycle after TD done.
        b = cyc;
        run(1'b1);
        at(b + 6); pulse_rec(1'b1);
        at(b + 12); pulse_td(1'b0, 1'b0);
        snap(40, 0, 1, 1, 1, 0, 3'd6, 4'b0000);
        at(b + 22); expect_done(b + 23, 4'b0010, 2'd1, 2'b01, 1'b1); pulse_td(1'b0, 1'b0);
        repeat (3) tick();

        // Timeout in MB_WAIT (entered at b+3): DONE 16 cycles after entry.
        b = cyc;
        expect_done(b + 19, 4'b0001, 2'd1, 2'b00, 1'b0);
        run(1'b0);
        at(b + 18);
        snap(50, 0, 1, 0, 1, 0, 3'd3, 4'b0000);
        at(b + 22);

        // Event on the last counted cycle beats the timeout.
        b = cyc;
        run(1'b0);
        at(b + 18);
        snap(60, 0, 1, 0, 1, 0, 3'd3, 4'b0000);
        expect_done(b + 19, 4'b1000, 2'd1, 2'b00, 1'b0);
        pulse_td(1'b1, 1'b0);
        repeat (3) tick();

        // Stray test_done in IDLE is ignored; status holds.
        pulse_td(1'b0, 1'b0);
        snap(70, 0, 0, 0, 0, 0, 3'd0, 4'b1000);
        tick();
        snap(71, 0, 0, 0, 0, 0, 3'd0, 4'b1000);
        tick();

        // run_req while busy ignored; reset during TD_WAIT aborts without START on release.
        b = cyc;
        run(1'b1);
        snap(72, 0, 1, 1, 1, 0, 3'd4, 4'b0000);
        at(b + 5); run(1'b0);
        snap(73, 0, 1, 1, 1, 0, 3'd6, 4'b0000);
        at(b + 12); pulse_td(1'b0, 1'b0);
        at(b + 15);
        #2 rst_n = 1'b0;
        snap(74, 0, 0, 0, 0, 0, 3'd0, 4'b0000);
        tick();
        snap(75, 0, 0, 0, 0, 0, 3'd0, 4'b0000);
        #2 rst_n = 1'b1;
        tick();
        snap(76, 0, 0, 0, 0, 0, 3'd0, 4'b0000);
        tick();
        snap(77, 0, 0, 0, 0, 0, 3'd0, 4'b0000);
        tick();

        // Sequencer is usable again after the abort.
        b = cyc;
        run(1'b0);
        at(b + 2);
        snap(80, 1, 1, 0, 1, 0, 3'd2, 4'b0000);
        at(b + 12); expect_done(b + 13, 4'b1000, 2'd1, 2'b00, 1'b0); pulse_td(1'b1, 1'b0);
        repeat (4) tick();

        end_req = 1'b1;
        repeat (5) if (!end_ack) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/strait_selftest_sequencer.md
# strait_selftest_sequencer

Power-on self-test sequencer sitting directly upstream of the STRAIT accelerator top. On one host request it drives START/test_mode/BIST_mode to run MBIST, then LBIST (SA then TD), then waits for BISR weight reallocation to finish. It latches MBIST_FAIL, TD_error_flag, recovery_success and a per-phase timeout into a sticky status word for the host.

## Interface
- TIMEOUT_CYCLES, 4096, max cycles spent in any wait state before abort
- CNT_WIDTH, $clog2(TIMEOUT_CYCLES+1), timeout counter width

Ports:
- clk  input  1  single clock
- rst_n  input  1  asynchronous, active-low reset
- run_req  input  1  host request, 1-cycle pulse; accepted only in IDLE
- skip_mbist  input  1  sampled with accepted run_req; 1 = go straight to LBIST
- START  output  1  1-cycle start pulse to STRAIT
- test_mode  output  1  to STRAIT test_mode
- BIST_mode  output  1  to STRAIT BIST_mode (0 MBIST, 1 LBIST)
- test_done  input  1  from STRAIT; pulses at end of MBIST, SA, TD
- MBIST_FAIL  input  1  from STRAIT, valid with MBIST test_done
- TD_error_flag  input  1  from STRAIT, valid with TD test_done
- recovery_done  input  1  from STRAIT BISR
- recovery_success  input  1  from STRAIT BISR, valid with recovery_done
- busy  output  1  high while a sequence runs
- seq_done  output  1  1-cycle pulse at sequence end
- phase  output  3  current state encoding
- mbist_fail_o, td_error_o, repair_ok_o, timeout_o  output  1 each  sticky status

## Operation
- States (phase code): IDLE 0, MB_SETUP 1, MB_START 2, MB_WAIT 3, LB_SETUP 4, LB_START 5, SA_WAIT/TD_WAIT 6 (internal flag distinguishes), REPAIR_WAIT 7; DONE is a 1-cycle state reported as phase 0.
- IDLE: run_req -> clear all status, rec_seen, counter; skip_mbist=0 -> MB_SETUP, else LB_SETUP.
- MB_SETUP: test_mode=1, BIST_mode=0 -> MB_START.
- MB_START: START=1 -> MB_WAIT.
- MB_WAIT: on test_done latch mbist_fail_o=MBIST_FAIL; fail -> DONE (LBIST skipped); pass -> LB_SETUP.
- LB_SETUP: test_mode=1, BIST_mode=1 -> LB_START. LB_START: START=1 -> SA_WAIT.
- SA_WAIT: test_done -> TD_WAIT. TD_WAIT: test_done -> latch td_error_o=TD_error_flag -> REPAIR_WAIT.
- REPAIR_WAIT: recovery_done (or rec_seen) -> repair_ok_o=recovery_success -> DONE.
- rec_seen: sticky, sets on recovery_done in any state from LB_START to REPAIR_WAIT, latching recovery_success; lets an early recovery_done complete REPAIR_WAIT on entry.
- DONE: seq_done=1, test_mode=0, BIST_mode=0, busy=0 -> IDLE.
- Timeout: counter clears on entry to every WAIT state, +1 per cycle inside; reaching TIMEOUT_CYCLES-1 without the awaited event sets timeout_o=1 -> DONE. Event and timeout on same cycle: event wins.
- test_done outside a WAIT state is ignored. run_req while busy is ignored.
- Status holds after DONE until next accepted run_req.

## Timing
- All outputs registered. Reset: START=0, test_mode=0, BIST_mode=0, busy=0, seq_done=0, phase=0, all status 0, counter 0, state IDLE.
- run_req at cycle N -> busy=1, test_mode=1 at N+1; START=1 at N+2 only. BIST_mode is stable at least one cycle before and after START.
- test_done at cycle M in MB_WAIT (pass) -> BIST_mode=1 at M+1, START at M+2.
- Awaited event at cycle K -> status visible at K+1; final event -> seq_done and busy=0 at K+1, phase=0.
- Reset asserted mid-sequence: all outputs return to reset values asynchronously; no START pulse on release.

## Test plan
- Clean run: skip_mbist=0, test_done 10 cycles after each START, MBIST_FAIL=0, TD_error_flag=0, recovery_done+success 5 cycles after TD done -> two START pulses, seq_done once, status 0/0/1/0.
- MBIST fail: MBIST_FAIL=1 with first test_done -> mbist_fail_o=1, seq_done next cycle, no second START, BIST_mode never 1.
- skip_mbist=1, TD_error_flag=1, recovery_success=0 -> single START with BIST_mode=1, td_error_o=1, repair_ok_o=0.
- Early recovery_done during SA_WAIT, then TD test_done -> seq_done exactly 1 cycle after TD done, repair_ok_o from early sample.
- TIMEOUT_CYCLES=16, no test_done after START -> timeout_o=1, seq_done 16 cycles after MB_WAIT entry; event on cycle 15 -> no timeout.
- rst_n low during TD_WAIT, run_req during busy, stray test_done in IDLE -> reset values immediately, ignored request, no state change.
